stream_read_mover: RTL and testbench

- DMA read engine that feeds the accelerator's stream crossbar.
- Takes one read command at a time (address, byte length, stream destination, user tag, last flag) from the source command FIFO.
- Issues AXI4 read bursts on its master read channel and forwards the returned data beats as an AXI-stream to the input buffer, tagged with the command's dest/user.
- Runs entirely in the aclk domain.

---
 rtl/stream_read_mover.sv | 181 ++++++++++++++++++
 tb/tb_stream_read_mover.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_read_mover.sv
// stream_read_mover: DMA read engine. Splits one command into AXI4 INCR read
// bursts (capped by MAX_BURST and 4 KB page boundaries) and forwards the
// returned beats as an AXI-stream tagged with the command's dest/user.
module stream_read_mover #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEST_WIDTH = 3,
  parameter int unsigned USER_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 21,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  // command
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DEST_WIDTH-1:0] cmd_dest,
  input  logic [USER_WIDTH-1:0] cmd_user,
  input  logic                  cmd_last,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  // AXI read address
  output logic [ADDR_WIDTH-1:0] ar_addr,
  output logic [7:0]            ar_len,
  output logic [2:0]            ar_size,
  output logic [1:0]            ar_burst,
  output logic                  ar_valid,
  input  logic                  ar_ready,
  // AXI read data
  input  logic [DATA_WIDTH-1:0] r_data,
  input  logic [1:0]            r_resp,
  input  logic                  r_last,
  input  logic                  r_valid,
  output logic                  r_ready,
  // stream out
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [DEST_WIDTH-1:0] m_dest,
  output logic [USER_WIDTH-1:0] m_user,
  output logic                  m_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  // status
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned BB      = DATA_WIDTH / 8;
  localparam int unsigned BB_LOG2 = $clog2(BB);
  localparam int unsigned BCNT_W  = 9;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_rem;
  logic [BCNT_W-1:0]     r_bcnt;
  logic [DEST_WIDTH-1:0] r_dest;
  logic [USER_WIDTH-1:0] r_user;
  logic                  r_cmd_last;
  logic                  r_err;
  logic                  r_cmd_ready;
  logic                  r_ar_valid;
  logic [ADDR_WIDTH-1:0] r_ar_addr;
  logic [7:0]            r_ar_len;

  logic [ADDR_WIDTH-1:0] w_cmd_addr;
  logic [LEN_WIDTH-1:0]  w_cmd_beats;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic [LEN_WIDTH-1:0]  w_next_rem;
  logic [BCNT_W-1:0]     w_first_burst;
  logic [BCNT_W-1:0]     w_next_burst;
  logic                  w_in_data;
  logic                  w_xfer;
  logic                  w_bcnt_last;

  // Beats in the next burst: min(remaining, MAX_BURST, beats left in 4 KB page)
  function automatic logic [BCNT_W-1:0] f_burst(input logic [ADDR_WIDTH-1:0] a,
                                                input logic [LEN_WIDTH-1:0]  rem);
    logic [12:0]          page;
    logic [LEN_WIDTH-1:0] n;
    page = (13'd4096 - {1'b0, a[11:0]}) >> BB_LOG2;
    n    = LEN_WIDTH'(page);
    if (n > LEN_WIDTH'(MAX_BURST)) n = LEN_WIDTH'(MAX_BURST);
    if (rem < n) n = rem;
    return BCNT_W'(n);
  endfunction

  assign w_cmd_addr    = cmd_addr & ~(ADDR_WIDTH'(BB - 1));
  assign w_cmd_beats   = cmd_len >> BB_LOG2;
  assign w_next_addr   = r_addr + ADDR_WIDTH'(BB);
  assign w_next_rem    = r_rem - LEN_WIDTH'(1);
  assign w_first_burst = f_burst(w_cmd_addr, w_cmd_beats);
  assign w_next_burst  = f_burst(w_next_addr, w_next_rem);
  assign w_in_data     = (r_state == S_DATA);
  assign w_xfer        = w_in_data & r_valid & m_ready;
  assign w_bcnt_last   = (r_bcnt == BCNT_W'(1));

  // R -> stream pass-through, only live while a burst is being received
  assign r_ready   = w_in_data & m_ready;
  assign m_valid   = w_in_data & r_valid;
  assign m_data    = w_in_data ? r_data : '0;
  assign m_last    = w_in_data & r_valid & r_cmd_last & (r_rem == LEN_WIDTH'(1));
  assign m_dest    = r_dest;
  assign m_user    = r_user;

  assign cmd_ready = r_cmd_ready;
  assign ar_valid  = r_ar_valid;
  assign ar_addr   = r_ar_addr;
  assign ar_len    = r_ar_len;
  assign ar_size   = 3'(BB_LOG2);
  assign ar_burst  = 2'b01;
  assign busy      = (r_state != S_IDLE);
  assign err       = r_err;

  // Command / burst sequencing FSM with registered AR and handshake outputs
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_rem       <= '0;
      r_bcnt      <= '0;
      r_dest      <= '0;
      r_user      <= '0;
      r_cmd_last  <= 1'b0;
      r_err       <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_ar_valid  <= 1'b0;
      r_ar_addr   <= '0;
      r_ar_len    <= '0;
    end else begin
      r_cmd_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // the !r_cmd_ready guard keeps a still-held cmd_valid from re-latching
          if (cmd_valid && !r_cmd_ready) begin
            r_addr      <= w_cmd_addr;
            r_rem       <= w_cmd_beats;
            r_dest      <= cmd_dest;
            r_user      <= cmd_user;
            r_cmd_last  <= cmd_last;
            r_cmd_ready <= 1'b1;
            if (w_cmd_beats != '0) begin
              r_state    <= S_ADDR;
              r_ar_valid <= 1'b1;
              r_ar_addr  <= w_cmd_addr;
              r_ar_len   <= 8'(w_first_burst - BCNT_W'(1));
            end
          end
        end
        S_ADDR: begin
          if (ar_ready) begin
            r_ar_valid <= 1'b0;
            r_bcnt     <= BCNT_W'(r_ar_len) + BCNT_W'(1);
            r_state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            // bad response or r_last out of step with our own beat count
            if ((r_resp != 2'b00) || (r_last != w_bcnt_last)) r_err <= 1'b1;
            r_rem  <= w_next_rem;
            r_addr <= w_next_addr;
            r_bcnt <= r_bcnt - BCNT_W'(1);
            if (w_bcnt_last) begin
              if (r_rem == LEN_WIDTH'(1)) begin
                r_state <= S_IDLE;
              end else begin
                r_state    <= S_ADDR;
                r_ar_valid <= 1'b1;
                r_ar_addr  <= w_next_addr;
                r_ar_len   <= 8'(w_next_burst - BCNT_W'(1));
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_read_mover.sv
// Directed bench for stream_read_mover: acts as command source, AXI read
// slave and stream sink, checking every handshake against hand-computed values.
module tb_stream_read_mover;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [63:0] cmd_addr;
  logic [20:0] cmd_len;
  logic [2:0]  cmd_dest;
  logic [7:0]  cmd_user;
  logic        cmd_last;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [63:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        ar_valid;
  logic        ar_ready;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic        r_valid;
  logic        r_ready;
  logic [63:0] m_data;
  logic [2:0]  m_dest;
  logic [7:0]  m_user;
  logic        m_last;
  logic        m_valid;
  logic        m_ready;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  // per-command context
  int          g_id = 0;
  int          g_beat;
  int          g_nbeats;
  logic        g_last;
  logic [2:0]  g_dest;
  logic [7:0]  g_user;
  int          g_err_beat;
  bit          g_rnd;
  int          g_k = 0;

  stream_read_mover dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_dest(cmd_dest),
    .cmd_user(cmd_user), .cmd_last(cmd_last), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_valid(r_valid),
    .r_ready(r_ready),
    .m_data(m_data), .m_dest(m_dest), .m_user(m_user), .m_last(m_last),
    .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .err(err)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pattern(input int id, input int beat);
    return {16'hC0DE, 16'(id), 32'(beat)};
  endfunction

  // Present a command and wait for its one-cycle cmd_ready pulse
  task automatic send_cmd(input logic [63:0] addr, input int nbeats, input logic [2:0] dest,
                          input logic [7:0] user, input logic last, input int err_beat,
                          input bit rnd);
    bit seen;
    g_id++;
    g_beat = 0; g_nbeats = nbeats; g_last = last; g_dest = dest; g_user = user;
    g_err_beat = err_beat; g_rnd = rnd;
    @(negedge aclk);
    cmd_addr = addr; cmd_len = 21'(nbeats * 8); cmd_dest = dest; cmd_user = user;
    cmd_last = last; cmd_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      if (cmd_ready) begin seen = 1'b1; break; end
    end
    chk("cmd_ready_pulse", 64'(seen), 64'd1);
    chk("busy_after_accept", 64'(busy), 64'(nbeats != 0));
    cmd_valid = 1'b0;
    @(negedge aclk);
    chk("cmd_ready_single", 64'(cmd_ready), 64'd0);
  endtask

  // Serve one AR with expected address/len, then up to max_beats data beats
  task automatic do_burst(input logic [63:0] exp_addr, input logic [7:0] exp_len,
                          input int max_beats);
    bit found;
    int n;
    int sent;
    int cyc;
    n = int'(exp_len) + 1;
    if (max_beats < n) n = max_beats;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ar_valid) begin found = 1'b1; break; end
      @(negedge aclk);
    end
    chk("ar_valid_seen", 64'(found), 64'd1);
    if (!found) return;
    chk("ar_addr", ar_addr, exp_addr);
    chk("ar_len", 64'(ar_len), 64'(exp_len));
    chk("ar_size", 64'(ar_size), 64'd3);
    chk("ar_burst", 64'(ar_burst), 64'd1);
    ar_ready = 1'b1;
    @(negedge aclk);
    ar_ready = 1'b0;
    sent = 0;
    cyc = 0;
    while (sent < n && cyc < 400) begin
      g_k++;
      r_valid = g_rnd ? ((g_k % 5) != 2) : 1'b1;
      m_ready = g_rnd ? (((g_k * 3) % 7) < 4) : 1'b1;
      r_data  = pattern(g_id, g_beat);
      r_last  = (sent == int'(exp_len));
      r_resp  = (g_beat == g_err_beat) ? 2'b10 : 2'b00;
      #1;
      chk("r_ready_tracks", 64'(r_ready), 64'(m_ready));
      chk("m_valid_tracks", 64'(m_valid), 64'(r_valid));
      chk("ar_quiet_in_data", 64'(ar_valid), 64'd0);
      if (r_valid && m_ready) begin
        chk("m_data", m_data, pattern(g_id, g_beat));
        chk("m_dest", 64'(m_dest), 64'(g_dest));
        chk("m_user", 64'(m_user), 64'(g_user));
        chk("m_last", 64'(m_last), 64'(g_last && (g_beat == g_nbeats - 1)));
        sent++;
        g_beat++;
      end
      @(negedge aclk);
      cyc++;
    end
    chk("burst_done", 64'(sent), 64'(n));
    r_valid = 1'b0; r_last = 1'b0; r_resp = 2'b00; m_ready = 1'b1;
  endtask

  task automatic finish_cmd(input logic exp_err);
    chk("busy_done", 64'(busy), 64'd0);
    chk("ar_idle", 64'(ar_valid), 64'd0);
    chk("err_state", 64'(err), 64'(exp_err));
  endtask

  initial begin
    aresetn = 1'b0;
    cmd_addr = '0; cmd_len = '0; cmd_dest = '0; cmd_user = '0; cmd_last = 1'b0;
    cmd_valid = 1'b0; ar_ready = 1'b0;
    r_data = '0; r_resp = 2'b00; r_last = 1'b0; r_valid = 1'b0; m_ready = 1'b1;
    repeat (3) @(negedge aclk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_ar_valid", 64'(ar_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    aresetn = 1'b1;
    @(negedge aclk);

    // 256 bytes, two 16-beat bursts, tlast on beat 32
    send_cmd(64'h1000, 32, 3'd2, 8'h5A, 1'b1, -1, 1'b0);
    do_burst(64'h1000, 8'd15, 999);
    do_burst(64'h1080, 8'd15, 999);
    finish_cmd(1'b0);

    // 128 bytes starting 64 bytes below a 4 KB boundary, no tlast
    send_cmd(64'h1FC0, 16, 3'd5, 8'hA3, 1'b0, -1, 1'b0);
    do_burst(64'h1FC0, 8'd7, 999);
    do_burst(64'h2000, 8'd7, 999);
    finish_cmd(1'b0);

    // zero-length command: ack only
    send_cmd(64'h7000, 0, 3'd1, 8'h11, 1'b1, -1, 1'b0);
    r_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("len0_ar_valid", 64'(ar_valid), 64'd0);
      chk("len0_m_valid", 64'(m_valid), 64'd0);
      chk("len0_busy", 64'(busy), 64'd0);
      @(negedge aclk);
    end
    r_valid = 1'b0;

    // 40 beats with ready/valid gaps
    send_cmd(64'h3000, 40, 3'd7, 8'h3C, 1'b1, -1, 1'b1);
    do_burst(64'h3000, 8'd15, 999);
    do_burst(64'h3080, 8'd15, 999);
    do_burst(64'h3100, 8'd7, 999);
    finish_cmd(1'b0);

    // SLVERR on beat 3: flagged, data still forwarded, command completes
    send_cmd(64'h4000, 8, 3'd3, 8'h77, 1'b1, 2, 1'b0);
    do_burst(64'h4000, 8'd7, 999);
    finish_cmd(1'b1);

    // err remains set across a clean command
    send_cmd(64'h4100, 4, 3'd0, 8'h01, 1'b0, -1, 1'b0);
    do_burst(64'h4100, 8'd3, 999);
    finish_cmd(1'b1);

    // reset in the middle of a burst
    send_cmd(64'h5000, 16, 3'd6, 8'hEE, 1'b1, -1, 1'b0);
    do_burst(64'h5000, 8'd15, 5);
    r_valid = 1'b1; m_ready = 1'b1; r_data = 64'hFFFF_FFFF_FFFF_FFFF;
    aresetn = 1'b0;
    #1;
    chk("mid_rst_m_valid", 64'(m_valid), 64'd0);
    chk("mid_rst_r_ready", 64'(r_ready), 64'd0);
    chk("mid_rst_m_data", m_data, 64'd0);
    chk("mid_rst_m_dest", 64'(m_dest), 64'd0);
    chk("mid_rst_m_user", 64'(m_user), 64'd0);
    chk("mid_rst_ar_valid", 64'(ar_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_err", 64'(err), 64'd0);
    @(negedge aclk);
    r_valid = 1'b0;
    aresetn = 1'b1;
    @(negedge aclk);

    // fresh command after reset
    send_cmd(64'h6000, 4, 3'd4, 8'h99, 1'b1, -1, 1'b0);
    do_burst(64'h6000, 8'd3, 999);
    finish_cmd(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
